byte_sort_controller: RTL and testbench

- Sequential controller that sorts N bytes into ascending order.
- Uses exactly one instance of the team's `eight_bit_comparator`, time-shared across all compare steps of a fixed-schedule bubble sort.
- Accepts bytes on a valid/ready input stream and returns them sorted on a valid/ready output stream.
- Sits between a byte producer and consumer as the sequencer that gives the comparator datapath its purpose.

---
 rtl/byte_sort_controller_pkg.sv | 13 +
 rtl/eight_bit_comparator.sv | 14 +
 rtl/byte_sort_controller.sv | 146 ++++++++++++++
 tb/tb_byte_sort_controller.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/byte_sort_controller_pkg.sv
// Shared definitions for the byte sort controller: FSM encodings and sizing limits.
package byte_sort_controller_pkg;

   localparam int MAX_N = 8;
   localparam int IDX_W = 3;

   typedef enum logic [1:0] {
      ST_LOAD   = 2'd0,
      ST_SORT   = 2'd1,
      ST_UNLOAD = 2'd2
   } state_t;

endpackage

// File: rtl/eight_bit_comparator.sv
// Unsigned 8-bit magnitude comparator with one-hot greater/lower/equal outputs.
module eight_bit_comparator (
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic       greater,
   output logic       lower,
   output logic       equal
);

   assign greater = (a > b);
   assign lower   = (a < b);
   assign equal   = (a == b);

endmodule

// File: rtl/byte_sort_controller.sv
// Loads N bytes, bubble-sorts them with one shared comparator on a fixed schedule,
// then streams them out in ascending order.
//
// state     | meaning
// ST_LOAD   | accepting bytes into mem[k]
// ST_SORT   | one compare/swap of mem[i], mem[i+1] per cycle, N(N-1)/2 cycles
// ST_UNLOAD | presenting mem[k] on the output stream
module byte_sort_controller
   import byte_sort_controller_pkg::*;
#(
   parameter int N = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   output logic       out_valid,
   output logic [7:0] out_data,
   input  logic       out_ready,
   output logic       busy,
   output logic [5:0] swap_count
);

   localparam logic [IDX_W-1:0] K_LAST = IDX_W'(N - 1);
   localparam logic [IDX_W-1:0] P_LAST = IDX_W'(N - 2);

   state_t           state;
   state_t           state_nxt;
   logic [7:0]       mem [MAX_N];
   logic [IDX_W-1:0] k;
   logic [IDX_W-1:0] p;
   logic [IDX_W-1:0] i;
   logic [IDX_W-1:0] i_nxt;
   logic [IDX_W-1:0] i_last;
   logic [7:0]       cmp_a;
   logic [7:0]       cmp_b;
   logic             cmp_greater;
   logic             cmp_lower;
   logic             cmp_equal;
   logic             do_swap;

   assign i_nxt  = i + IDX_W'(1);
   assign i_last = P_LAST - p;
   assign cmp_a  = mem[i];
   assign cmp_b  = mem[i_nxt];

   eight_bit_comparator u_cmp (
      .a       (cmp_a),
      .b       (cmp_b),
      .greater (cmp_greater),
      .lower   (cmp_lower),
      .equal   (cmp_equal)
   );

   // Equal entries are kept in place, which is what makes the sort stable.
   assign do_swap = cmp_greater & ~(cmp_lower | cmp_equal);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_LOAD;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_LOAD: begin
            if (in_valid && (k == K_LAST)) begin
               state_nxt = ST_SORT;
            end
         end
         ST_SORT: begin
            if (p == P_LAST) begin
               state_nxt = ST_UNLOAD;
            end
         end
         ST_UNLOAD: begin
            if (out_ready && (k == K_LAST)) begin
               state_nxt = ST_LOAD;
            end
         end
         default: state_nxt = ST_LOAD;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int j = 0; j < MAX_N; j++) begin
            mem[j] <= 8'd0;
         end
         k          <= '0;
         p          <= '0;
         i          <= '0;
         swap_count <= 6'd0;
      end else begin
         case (state)
            ST_LOAD: begin
               if (in_valid) begin
                  mem[k] <= in_data;
                  if (k == K_LAST) begin
                     k          <= '0;
                     p          <= '0;
                     i          <= '0;
                     swap_count <= 6'd0;
                  end else begin
                     k <= k + IDX_W'(1);
                  end
               end
            end
            ST_SORT: begin
               if (do_swap) begin
                  mem[i]     <= cmp_b;
                  mem[i_nxt] <= cmp_a;
                  swap_count <= swap_count + 6'd1;
               end
               if (i == i_last) begin
                  i <= '0;
                  p <= p + IDX_W'(1);
               end else begin
                  i <= i_nxt;
               end
            end
            ST_UNLOAD: begin
               if (out_ready) begin
                  if (k == K_LAST) begin
                     k <= '0;
                  end else begin
                     k <= k + IDX_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Outputs come from registered state only; no handshake input reaches them.
   assign in_ready  = (state == ST_LOAD);
   assign out_valid = (state == ST_UNLOAD);
   assign busy      = (state == ST_SORT);
   assign out_data  = (state == ST_UNLOAD) ? mem[k] : 8'd0;

endmodule

// File: tb/tb_byte_sort_controller.sv
// Directed and randomized batches checked against a rank/inversion reference model.
module tb_byte_sort_controller;

   localparam int N     = 4;
   localparam int LIMIT = 200;
   localparam int STEPS = N * (N - 1) / 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'd0;
   logic       in_ready;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_ready = 1'b0;
   logic       busy;
   logic [5:0] swap_count;

   int vectors = 0;
   int errors  = 0;

   logic [7:0] cur [N];
   logic [7:0] exp_sorted [N];
   int         exp_swaps;

   byte_sort_controller #(.N(N)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_ready  (out_ready),
      .busy       (busy),
      .swap_count (swap_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Stable rank gives each byte's output slot; inversion count equals bubble-sort swaps.
   task automatic model();
      int pos;
      exp_swaps = 0;
      for (int a = 0; a < N; a++) begin
         pos = 0;
         for (int b = 0; b < N; b++) begin
            if (cur[b] < cur[a] || (cur[b] == cur[a] && b < a)) pos++;
            if (b > a && cur[a] > cur[b]) exp_swaps++;
         end
         exp_sorted[pos] = cur[a];
      end
   endtask

   function automatic logic pick(input int mode, input int cyc);
      if (mode == 0) return 1'b1;
      if (mode == 1) return (cyc % 2) == 0;
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic do_load(input int mode);
      int  idx = 0;
      int  cyc = 0;
      logic go, rdy;
      out_ready = 1'b1;
      while (idx < N && cyc < LIMIT) begin
         go = pick(mode, cyc);
         in_valid = go;
         in_data  = go ? cur[idx] : 8'($urandom);
         chk("load_in_ready", 32'(in_ready), 32'd1);
         chk("load_out_valid", 32'(out_valid), 32'd0);
         chk("load_busy", 32'(busy), 32'd0);
         rdy = in_ready;
         @(posedge clk); #1;
         if (go && rdy) idx++;
         cyc++;
      end
      chk("load_done", 32'(idx), 32'(N));
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'hEE;
   endtask

   task automatic do_sort();
      int cnt = 0;
      chk("busy_latency", 32'(busy), 32'd1);
      while (busy && cnt < LIMIT) begin
         chk("sort_in_ready", 32'(in_ready), 32'd0);
         chk("sort_out_valid", 32'(out_valid), 32'd0);
         cnt++;
         @(posedge clk); #1;
      end
      chk("sort_cycles", 32'(cnt), 32'(STEPS));
      chk("unload_follows", 32'(out_valid), 32'd1);
      chk("swap_count", 32'(swap_count), 32'(exp_swaps));
   endtask

   task automatic do_unload(input int mode);
      int  j = 0;
      int  cyc = 0;
      logic go, v;
      while (j < N && cyc < LIMIT) begin
         go = pick(mode, cyc);
         out_ready = go;
         v = out_valid;
         chk("unload_valid", 32'(v), 32'd1);
         chk("unload_data", 32'(out_data), 32'(exp_sorted[j]));
         @(posedge clk); #1;
         if (go && v) j++;
         cyc++;
      end
      chk("unload_done", 32'(j), 32'(N));
      in_valid  = 1'b0;
      out_ready = 1'b0;
      chk("post_in_ready", 32'(in_ready), 32'd1);
      chk("post_out_valid", 32'(out_valid), 32'd0);
      chk("post_out_data", 32'(out_data), 32'd0);
      chk("post_swap_hold", 32'(swap_count), 32'(exp_swaps));
   endtask

   task automatic run_batch(input logic [31:0] word, input int mode);
      for (int b = 0; b < N; b++) cur[b] = word[31 - 8*b -: 8];
      model();
      do_load(mode);
      do_sort();
      do_unload(mode);
   endtask

   initial begin
      #12;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_swaps", 32'(swap_count), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_batch(32'h40103020, 0);
      run_batch(32'hFFC00201, 0);
      run_batch(32'h80808080, 0);
      run_batch(32'h01020408, 0);
      run_batch(32'h40103020, 1);

      for (int b = 0; b < N; b++) cur[b] = 8'(32'h40103020 >> (24 - 8*b));
      model();
      do_load(0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #2;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_out_valid", 32'(out_valid), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      chk("midrst_swaps", 32'(swap_count), 32'd0);
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("postrst_out_valid", 32'(out_valid), 32'd0);
      run_batch(32'h03010200, 0);

      for (int t = 0; t < 12; t++) begin
         logic [31:0] w;
         w = $urandom;
         if (t % 4 == 3) w[15:8] = w[31:24];
         run_batch(w, t % 3);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
